// File: rtl/vga_timing_pipe.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pipe
// Brief    : Parametrised VGA timing generator with pixel-clock divider.
//            Issues pixel coordinates to a pixel source, delays sync/blank
//            flags by the source latency, then blanks and registers RGB.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_pipe #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int RGB_W     = 12,
    parameter int PIPE_LAT  = 2,
    parameter int XY_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    output logic             p_tick,
    output logic [XY_W-1:0]  x,
    output logic [XY_W-1:0]  y,
    output logic             video_on_raw,
    output logic             frame_start,
    input  logic [RGB_W-1:0] rgb_in,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [RGB_W-1:0] rgb
);

    localparam int c_h_total = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [XY_W-1:0]    c_h_last   = XY_W'(c_h_total - 1);
    localparam logic [XY_W-1:0]    c_v_last   = XY_W'(c_v_total - 1);
    localparam logic [XY_W-1:0]    c_h_disp   = XY_W'(H_DISPLAY);
    localparam logic [XY_W-1:0]    c_v_disp   = XY_W'(V_DISPLAY);
    localparam logic [XY_W-1:0]    c_hs_start = XY_W'(H_DISPLAY + H_FRONT);
    localparam logic [XY_W-1:0]    c_hs_end   = XY_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [XY_W-1:0]    c_vs_start = XY_W'(V_DISPLAY + V_FRONT);
    localparam logic [XY_W-1:0]    c_vs_end   = XY_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic               c_hs_act   = (HS_POL != 0);
    localparam logic               c_vs_act   = (VS_POL != 0);

    logic [c_div_w-1:0] r_div;
    logic               r_run;
    logic [XY_W-1:0]    r_x;
    logic [XY_W-1:0]    r_y;
    logic               w_tick;
    logic               w_vid0;
    logic               w_hs0;
    logic               w_vs0;
    logic [2:0]         w_last;    // {vid, hs, vs} of the last delay stage
    logic               r_video_on;
    logic               r_hsync;
    logic               r_vsync;
    logic [RGB_W-1:0]   r_rgb;

    // r_run masks the tick while in reset; needed when CLK_DIV==1 (div stuck at 0)
    assign w_tick = r_run && (r_div == c_div_last);

    // Pixel-clock divider: div wraps at CLK_DIV-1
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div <= '0;
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_div == c_div_last) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + c_div_w'(1);
            end
        end
    end

    // Horizontal / vertical counters, advancing once per pixel tick
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_tick) begin
            if (r_x == c_h_last) begin
                r_x <= '0;
                if (r_y == c_v_last) begin
                    r_y <= '0;
                end else begin
                    r_y <= r_y + XY_W'(1);
                end
            end else begin
                r_x <= r_x + XY_W'(1);
            end
        end
    end

    // Stage-0 flags decoded directly from the live coordinates
    always_comb begin
        w_vid0 = (r_x < c_h_disp) && (r_y < c_v_disp);
        w_hs0  = (r_x >= c_hs_start) && (r_x <= c_hs_end);
        w_vs0  = (r_y >= c_vs_start) && (r_y <= c_vs_end);
    end

    generate
        if (PIPE_LAT > 0) begin : g_pipe
            logic [2:0] r_stage [PIPE_LAT];

            // Flag delay line matching the pixel source latency
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        r_stage[i] <= '0;
                    end
                end else if (w_tick) begin
                    r_stage[0] <= {w_vid0, w_hs0, w_vs0};
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign w_last = r_stage[PIPE_LAT-1];
        end else begin : g_nopipe
            assign w_last = {w_vid0, w_hs0, w_vs0};
        end
    endgenerate

    // Output register: aligned flags, sync polarity, blanked colour
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_video_on <= 1'b0;
            r_hsync    <= ~c_hs_act;
            r_vsync    <= ~c_vs_act;
            r_rgb      <= '0;
        end else if (w_tick) begin
            r_video_on <= w_last[2];
            r_hsync    <= w_last[1] ? c_hs_act : ~c_hs_act;
            r_vsync    <= w_last[0] ? c_vs_act : ~c_vs_act;
            r_rgb      <= w_last[2] ? rgb_in : '0;
        end
    end

    assign p_tick       = w_tick;
    assign x            = r_x;
    assign y            = r_y;
    assign video_on_raw = w_vid0;
    assign frame_start  = w_tick && (r_x == c_h_last) && (r_y == c_v_last);
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign video_on     = r_video_on;
    assign rgb          = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_pipe
// Brief    : Self-checking bench for vga_timing_pipe. Two instances with a
//            reduced raster: A (CLK_DIV=4, PIPE_LAT=2) and B (CLK_DIV=1,
//            PIPE_LAT=0), opposite sync polarities. Expected aligned outputs
//            are queued when a coordinate is issued and compared on arrival.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_pipe;

    localparam int HD = 16, HF = 2, HS = 3, HB = 3;
    localparam int VD = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;

    typedef struct packed {
        logic        vid;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p_tick   [2];
    logic [9:0]  x        [2];
    logic [9:0]  y        [2];
    logic        vraw     [2];
    logic        fs       [2];
    logic        hsync    [2];
    logic        vsync    [2];
    logic        von      [2];
    logic [11:0] rgb      [2];
    logic [11:0] rgb_in   [2];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          mdiv [2];
    int          mx   [2];
    int          my   [2];
    bit          mrun [2];
    int          fs_cnt [2];
    logic [11:0] hist [2][3];
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clk = ~clk;

    vga_timing_pipe #(
        .CLK_DIV(4), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HS_POL(0), .VS_POL(1), .RGB_W(12), .PIPE_LAT(2), .XY_W(10)
    ) u_a (
        .clk(clk), .rst(rst), .p_tick(p_tick[0]), .x(x[0]), .y(y[0]),
        .video_on_raw(vraw[0]), .frame_start(fs[0]), .rgb_in(rgb_in[0]),
        .hsync(hsync[0]), .vsync(vsync[0]), .video_on(von[0]), .rgb(rgb[0])
    );

    vga_timing_pipe #(
        .CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HS_POL(1), .VS_POL(0), .RGB_W(12), .PIPE_LAT(0), .XY_W(10)
    ) u_b (
        .clk(clk), .rst(rst), .p_tick(p_tick[1]), .x(x[1]), .y(y[1]),
        .video_on_raw(vraw[1]), .frame_start(fs[1]), .rgb_in(rgb_in[1]),
        .hsync(hsync[1]), .vsync(vsync[1]), .video_on(von[1]), .rgb(rgb[1])
    );

    function automatic int div_of(int i); return (i == 0) ? 4 : 1; endfunction
    function automatic int lat_of(int i); return (i == 0) ? 2 : 0; endfunction
    function automatic logic hsp_of(int i); return (i == 0) ? 1'b0 : 1'b1; endfunction
    function automatic logic vsp_of(int i); return (i == 0) ? 1'b1 : 1'b0; endfunction

    function automatic exp_t blank(int i);
        exp_t e;
        e.vid = 1'b0;
        e.hs  = ~hsp_of(i);
        e.vs  = ~vsp_of(i);
        e.rgb = 12'h000;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic reset_model(input int i);
        mdiv[i] = 0;
        mx[i]   = 0;
        my[i]   = 0;
        mrun[i] = 1'b0;
        if (i == 0) begin
            q0.delete();
            repeat (lat_of(0) + 1) q0.push_back(blank(0));
        end else begin
            q1.delete();
            repeat (lat_of(1) + 1) q1.push_back(blank(1));
        end
    endtask

    // One clk: observe at negedge, drive source and rst, advance the model
    task automatic step(input logic r);
        exp_t  e;
        exp_t  o;
        bit    t;
        string n;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n = (i == 0) ? "A" : "B";
            t = mrun[i] && (mdiv[i] == div_of(i) - 1);
            check({n, ".p_tick"},       32'(p_tick[i]), 32'(t));
            check({n, ".x"},            32'(x[i]),      32'(mx[i]));
            check({n, ".y"},            32'(y[i]),      32'(my[i]));
            check({n, ".video_on_raw"}, 32'(vraw[i]),   32'(mx[i] < HD && my[i] < VD));
            check({n, ".frame_start"},  32'(fs[i]),     32'(t && mx[i] == HT-1 && my[i] == VT-1));
            if (fs[i] === 1'b1) fs_cnt[i]++;
            if (!mrun[i]) begin
                o = blank(i);
                check({n, ".rst_video_on"}, 32'(von[i]),   32'(o.vid));
                check({n, ".rst_hsync"},    32'(hsync[i]), 32'(o.hs));
                check({n, ".rst_vsync"},    32'(vsync[i]), 32'(o.vs));
                check({n, ".rst_rgb"},      32'(rgb[i]),   32'(o.rgb));
            end
            if (t) begin
                e.vid = (mx[i] < HD) && (my[i] < VD);
                e.hs  = (mx[i] >= HD+HF && mx[i] < HD+HF+HS) ? hsp_of(i) : ~hsp_of(i);
                e.vs  = (my[i] >= VD+VF && my[i] < VD+VF+VS) ? vsp_of(i) : ~vsp_of(i);
                e.rgb = e.vid ? {4'(mx[i]), 4'(my[i]), 4'hA} : 12'h000;
                if (i == 0) begin
                    q0.push_back(e);
                    o = q0.pop_front();
                end else begin
                    q1.push_back(e);
                    o = q1.pop_front();
                end
                check({n, ".video_on"}, 32'(von[i]),   32'(o.vid));
                check({n, ".hsync"},    32'(hsync[i]), 32'(o.hs));
                check({n, ".vsync"},    32'(vsync[i]), 32'(o.vs));
                check({n, ".rgb"},      32'(rgb[i]),   32'(o.rgb));
                // Pixel source: returns colour for coordinates issued lat ticks ago
                hist[i][2] = hist[i][1];
                hist[i][1] = hist[i][0];
                hist[i][0] = {x[i][3:0], y[i][3:0], 4'hA};
                rgb_in[i]  = hist[i][lat_of(i)];
            end else begin
                rgb_in[i] = 12'($urandom);
            end
        end
        rst = r;
        for (int i = 0; i < 2; i++) begin
            if (!r) begin
                reset_model(i);
            end else begin
                t = mrun[i] && (mdiv[i] == div_of(i) - 1);
                if (t) begin
                    if (mx[i] == HT-1) begin
                        mx[i] = 0;
                        my[i] = (my[i] == VT-1) ? 0 : my[i] + 1;
                    end else begin
                        mx[i] = mx[i] + 1;
                    end
                end
                mdiv[i] = (mdiv[i] == div_of(i) - 1) ? 0 : mdiv[i] + 1;
                mrun[i] = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            reset_model(i);
            rgb_in[i] = 12'h000;
            fs_cnt[i] = 0;
            for (int k = 0; k < 3; k++) hist[i][k] = 12'h000;
        end

        repeat (5) step(1'b0);

        for (int i = 0; i < 2; i++) fs_cnt[i] = 0;
        repeat (2100) step(1'b1);
        check("A.frames", 32'(fs_cnt[0]), 32'd2);
        check("B.frames", 32'(fs_cnt[1]), 32'd8);

        // Mid-frame reset, then run through more than a frame again
        repeat (3) step(1'b0);
        repeat (1300) step(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
